cache_miss_arbiter: RTL

Shared miss-handling controller sitting between N private caches (I-cache, D-cache, and further ports) and the single RAM port. It takes level-held miss requests from every cache and grants the RAM to one cache at a time using round-robin arbitration. For the granted cache it runs an optional multi-beat dirty-line writeback, then a multi-beat refill, and returns a one-cycle done pulse. It generalises the fixed two-state-machine I/D controller to any port count and line length, and adds fairness and beat sequencing.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/cache_miss_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss controller and other blocks that
// share the single RAM port: FSM state encoding, defaults and port indices.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        REFILL = 2'd2,
        FIN    = 2'd3
    } state_t;

    localparam int DEFAULT_LINE_BEATS = 4;

    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requesting port at or
// after ptr, wrapping past the top port back to port 0.
module rr_arbiter
    import cache_pkg::*;
#(
    parameter int N     = 2,
    parameter int PTR_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_miss_arbiter.sv
// Shared miss controller: round-robin grants the RAM to one cache at a time,
// runs an optional dirty-line writeback and then the refill, beat by beat.
module cache_miss_arbiter
    import cache_pkg::*;
#(
    parameter int N_PORTS    = 2,
    parameter int LINE_BEATS = DEFAULT_LINE_BEATS,
    parameter int BEAT_W     = idx_w(LINE_BEATS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_PORTS-1:0] miss_req,
    input  logic [N_PORTS-1:0] miss_dirty,
    input  logic               ram_ready,
    output logic [N_PORTS-1:0] grant,
    output logic               ram_en,
    output logic               ram_we,
    output logic               ram_addr_sel,
    output logic [BEAT_W-1:0]  beat_idx,
    output logic               line_rd,
    output logic               line_we,
    output logic [N_PORTS-1:0] done,
    output logic               busy,
    output state_t             dbg_state
);

    localparam int                PTR_W     = idx_w(N_PORTS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    // RAM handshake: a beat transfers in every cycle where ram_en and
    // ram_ready are both high; ram_ready is ignored while ram_en is low.

    state_t             state_q, state_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               dirty_q, dirty_d;

    logic [N_PORTS-1:0] arb_grant;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   next_ptr;

    rr_arbiter #(
        .N     (N_PORTS),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (miss_req),
        .ptr   (rr_ptr_q),
        .grant (arb_grant)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    // The pointer moves to the port just past the one that finished.
    always_comb begin
        if (win_idx == PTR_W'(N_PORTS - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
            dirty_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            dirty_q  <= dirty_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        beat_d       = beat_q;
        dirty_d      = dirty_q;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr_sel = 1'b0;
        line_rd      = 1'b0;
        line_we      = 1'b0;
        done         = '0;

        case (state_q)
            IDLE: begin
                if (|miss_req) begin
                    grant_d = arb_grant;
                    dirty_d = |(arb_grant & miss_dirty);
                    beat_d  = '0;
                    state_d = dirty_d ? WB : REFILL;
                end
            end
            WB: begin
                ram_en       = 1'b1;
                ram_we       = 1'b1;
                ram_addr_sel = 1'b1;
                line_rd      = 1'b1;
                if (ram_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = REFILL;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            REFILL: begin
                ram_en  = 1'b1;
                line_we = ram_ready;
                if (ram_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = FIN;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            FIN: begin
                done     = grant_q;
                rr_ptr_d = next_ptr;
                grant_d  = '0;
                dirty_d  = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant     = grant_q;
    assign beat_idx  = beat_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
